ahblite_slave_mux_param: RTL and testbench
==========================================

// Module: ahblite_slave_mux_param
// PURPOSE
//  Parametrised AHB-lite slave-side response mux for the Cortex-M0 bus matrix; replaces fixed 13-port mux.
//  Registers HSEL during the address phase and steers HREADYOUT/HRESP/HRDATA from the data-phase slave.
//  Adds a built-in default slave: two-cycle ERROR for unmapped or multi-hot selects.
//  Adds a stall watchdog: a slave holding HREADYOUT low too long is aborted with ERROR.
// PARAMETERS
//  NUM_SLAVES      13  number of slave ports, 1..32
//  DATA_W          32  HRDATA width per port
//  TIMEOUT_CYCLES  256 stalled data-phase cycles before abort; 0 = watchdog disabled
//  CNT_W           9   watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  HCLK           in   1                  bus clock, all state on rising edge
//  HRESET         in   1                  synchronous reset, active-high
//  HREADY         in   1                  bus HREADY (fed back from HREADYOUT)
//  HTRANS         in   2                  address-phase transfer type; bit1=1 -> NONSEQ/SEQ
//  HSEL_VEC       in   NUM_SLAVES         address-phase selects, bit i = port i
//  HREADYOUT_VEC  in   NUM_SLAVES         slave HREADYOUT, bit i = port i
//  HRESP_VEC      in   NUM_SLAVES         slave HRESP, bit i = port i
//  HRDATA_VEC     in   NUM_SLAVES*DATA_W  slave HRDATA, port i at [i*DATA_W +: DATA_W]
//  TIMEOUT_CLR    in   1                  clears sticky TIMEOUT_FLAG
//  HREADYOUT      out  1                  muxed ready to master
//  HRESP          out  1                  muxed response, 1 = ERROR
//  HRDATA         out  DATA_W             muxed read data
//  TIMEOUT_FLAG   out  1                  sticky: watchdog abort occurred
//  SEL_ERR_FLAG   out  1                  sticky: multi-hot HSEL seen; cleared only by reset
// BEHAVIOUR
//  Reset: state=PASS, dp_sel=0, dp_act=0, cnt=0, flags=0 -> HREADYOUT=1, HRESP=0, HRDATA=0.
//  Address sample when HREADY=1: dp_sel<=HSEL_VEC, dp_act<=HTRANS[1]. Hold dp_sel/dp_act while HREADY=0.
//  bad = HREADY & HTRANS[1] & (HSEL_VEC==0 | HSEL_VEC not one-hot).
//  FSM states: PASS, ERR1, ERR2.
//   PASS: one-hot dp_sel -> outputs from that port; dp_sel==0 -> HREADYOUT=1, HRESP=0, HRDATA=0.
//   ERR1: HREADYOUT=0, HRESP=1, HRDATA=0.
//   ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
//  Transitions:
//   PASS->ERR1 on bad; ERR1->ERR2 always; ERR2->ERR1 on bad, else PASS.
//   PASS->ERR1 on watchdog expiry; bad and expiry cannot coincide (expiry implies HREADY=0).
//  ERROR timing: a bad address phase at cycle t gives ERR1 at t+1 and ERR2 at t+2.
//   This is the AHB two-cycle ERROR.
//  Multi-hot select: also sets SEL_ERR_FLAG. A multi-hot dp_sel is never muxed in PASS.
//  Watchdog (TIMEOUT_CYCLES>0):
//   stall = PASS & dp_act & (dp_sel!=0) & ~selected HREADYOUT.
//   cnt increments on stall; clears on ~stall or outside PASS.
//   stall with cnt==TIMEOUT_CYCLES-1 -> next state ERR1 and TIMEOUT_FLAG<=1.
//   So exactly TIMEOUT_CYCLES stalled cycles are visible before ERR1.
//  Abort exit: on ERR2 the hung slave is abandoned. The next sample overwrites dp_sel; its late outputs are ignored.
//  TIMEOUT_FLAG: TIMEOUT_CLR clears it; a set in the same cycle wins.
//  Slave HRESP=1 is passed through unchanged; the slave owns its own two-cycle sequence.
//  Reset mid-transfer (any state) returns to the reset values on the next edge.
//  HTRANS IDLE/BUSY with HSEL set: dp_act=0, and the port is still muxed, so its OKAY/ready passes through.
// TESTING
//  T1 NONSEQ port 5 (HSEL_VEC=1<<5), slave ready with HRDATA=0xCAFE0005 -> t+1: HREADYOUT=1, HRESP=0, HRDATA=0xCAFE0005.
//  T2 port 12 HREADYOUT low 3 cycles then high -> HREADYOUT tracks the slave, 3 wait states, no flags set.
//  T3 NONSEQ with HSEL_VEC=0 -> t+1 (0,1) then t+2 (1,1) for (HREADYOUT,HRESP); back-to-back bad phases repeat ERR1/ERR2.
//  T4 HSEL_VEC=0x0003 NONSEQ -> two-cycle ERROR, SEL_ERR_FLAG=1 persists until HRESET.
//  T5 TIMEOUT_CYCLES=4, port 2 never ready -> 4 stall cycles, then ERR1, ERR2; TIMEOUT_FLAG=1; TIMEOUT_CLR clears it.
//  T6 HRESET=1 during ERR1 or mid-stall -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, cnt=0.

Source files
------------

// File: rtl/ahblite_slave_mux_param.sv
// AHB-lite slave-side response mux with a built-in default slave (two-cycle ERROR for
// unmapped or multi-hot selects) and a stall watchdog that aborts hung slaves.
module ahblite_slave_mux_param #(
   parameter int NUM_SLAVES     = 13,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic                         HREADY,
   input  logic [1:0]                   HTRANS,
   input  logic [NUM_SLAVES-1:0]        HSEL_VEC,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_VEC,
   input  logic [NUM_SLAVES-1:0]        HRESP_VEC,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_VEC,
   input  logic                         TIMEOUT_CLR,
   output logic                         HREADYOUT,
   output logic                         HRESP,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         TIMEOUT_FLAG,
   output logic                         SEL_ERR_FLAG
);

   typedef enum logic [1:0] {PASS, ERR1, ERR2} state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   dpSel_q, dpSel_d;
   logic                    dpAct_q, dpAct_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    timeoutFlag_q, timeoutFlag_d;
   logic                    selErrFlag_q, selErrFlag_d;

   logic                    selOneHot;
   logic                    addrActive;
   logic                    bad;
   logic                    multiHot;
   logic                    stall;
   logic                    expire;
   logic                    portReady;
   logic                    portResp;
   logic [DATA_W-1:0]       portData;
   logic                    unusedTransBit;

   assign unusedTransBit = HTRANS[0];

   assign selOneHot  = $onehot(dpSel_q);
   assign addrActive = HREADY & HTRANS[1];
   assign bad        = addrActive & ~$onehot(HSEL_VEC);
   assign multiHot   = addrActive & (HSEL_VEC != '0) & ~$onehot(HSEL_VEC);

   // OR-reduce the selected port; only trusted when dpSel_q is one-hot.
   always_comb begin
      portReady = 1'b0;
      portResp  = 1'b0;
      portData  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (dpSel_q[i]) begin
            portReady = portReady | HREADYOUT_VEC[i];
            portResp  = portResp  | HRESP_VEC[i];
            portData  = portData  | HRDATA_VEC[i*DATA_W +: DATA_W];
         end
      end
   end

   assign stall  = (state_q == PASS) & dpAct_q & selOneHot & ~portReady;
   assign expire = (TIMEOUT_CYCLES > 0) && stall && (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = '0;
      case (state_q)
         PASS: begin
            if (selOneHot) begin
               HREADYOUT = portReady;
               HRESP     = portResp;
               HRDATA    = portData;
            end
            if (bad || expire) begin
               state_d = ERR1;
            end
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = ERR2;
         end
         ERR2: begin
            HRESP   = 1'b1;
            state_d = bad ? ERR1 : PASS;
         end
         default: state_d = PASS;
      endcase
   end

   // A stalled slave abandoned by the watchdog is dropped at the next address sample.
   always_comb begin
      dpSel_d       = HREADY ? HSEL_VEC : dpSel_q;
      dpAct_d       = HREADY ? HTRANS[1] : dpAct_q;
      cnt_d         = ((TIMEOUT_CYCLES > 0) && stall) ? cnt_q + CNT_W'(1) : '0;
      timeoutFlag_d = expire ? 1'b1 : (TIMEOUT_CLR ? 1'b0 : timeoutFlag_q);
      selErrFlag_d  = selErrFlag_q | multiHot;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q       <= PASS;
         dpSel_q       <= '0;
         dpAct_q       <= 1'b0;
         cnt_q         <= '0;
         timeoutFlag_q <= 1'b0;
         selErrFlag_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         dpSel_q       <= dpSel_d;
         dpAct_q       <= dpAct_d;
         cnt_q         <= cnt_d;
         timeoutFlag_q <= timeoutFlag_d;
         selErrFlag_q  <= selErrFlag_d;
      end
   end

   assign TIMEOUT_FLAG = timeoutFlag_q;
   assign SEL_ERR_FLAG = selErrFlag_q;

endmodule

// File: tb/tb_ahblite_slave_mux_param.sv
// Self-checking bench for ahblite_slave_mux_param: directed bus scenarios followed by random
// traffic, all compared each cycle against a transaction-level reference model.
module tb_ahblite_slave_mux_param;

   localparam int NS  = 13;
   localparam int DW  = 32;
   localparam int TMO = 4;
   localparam int CW  = 3;
   localparam logic [1:0]    IDLE   = 2'b00;
   localparam logic [1:0]    NONSEQ = 2'b10;
   localparam logic [NS-1:0] ALL    = '1;

   logic           clock = 1'b0;
   logic           reset;
   logic           hready;
   logic [1:0]     trans;
   logic [NS-1:0]  sel;
   logic [NS-1:0]  rdyVec;
   logic [NS-1:0]  respVec;
   logic [NS*DW-1:0] dataVec;
   logic           clr;
   logic           hreadyOut;
   logic           hresp;
   logic [DW-1:0]  hrdata;
   logic           tmoFlag;
   logic           selErrFlag;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model: errLeft counts remaining ERROR response cycles (2 = first, 1 = second).
   logic [NS-1:0] mSel     = '0;
   bit            mAct     = 1'b0;
   int            errLeft  = 0;
   int            stallCnt = 0;
   bit            mTmo     = 1'b0;
   bit            mSelErr  = 1'b0;
   logic          expReady;
   logic          expResp;
   logic [DW-1:0] expData;

   always #5 clock = ~clock;

   assign hready = hreadyOut;

   ahblite_slave_mux_param #(
      .NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
   ) dut (
      .HCLK(clock), .HRESET(reset), .HREADY(hready), .HTRANS(trans),
      .HSEL_VEC(sel), .HREADYOUT_VEC(rdyVec), .HRESP_VEC(respVec), .HRDATA_VEC(dataVec),
      .TIMEOUT_CLR(clr), .HREADYOUT(hreadyOut), .HRESP(hresp), .HRDATA(hrdata),
      .TIMEOUT_FLAG(tmoFlag), .SEL_ERR_FLAG(selErrFlag)
   );

   function automatic logic [NS-1:0] oneHot(input int p);
      logic [NS-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   function automatic int portIndex(input logic [NS-1:0] v);
      int idx;
      idx = -1;
      if ($countones(v) == 1) begin
         for (int i = 0; i < NS; i++) begin
            if (v[i]) idx = i;
         end
      end
      return idx;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelOutputs();
      int idx;
      idx = portIndex(mSel);
      expReady = 1'b1;
      expResp  = 1'b0;
      expData  = '0;
      if (errLeft == 2) begin
         expReady = 1'b0;
         expResp  = 1'b1;
      end else if (errLeft == 1) begin
         expResp = 1'b1;
      end else if (idx >= 0) begin
         expReady = rdyVec[idx];
         expResp  = respVec[idx];
         expData  = dataVec[idx*DW +: DW];
      end
   endtask

   task automatic modelStep();
      int  idx;
      int  ones;
      bit  transfer;
      bit  bad;
      bit  stalled;
      bit  expire;
      if (reset) begin
         mSel = '0; mAct = 1'b0; errLeft = 0; stallCnt = 0; mTmo = 1'b0; mSelErr = 1'b0;
      end else begin
         idx      = portIndex(mSel);
         ones     = $countones(sel);
         transfer = expReady && trans[1];
         bad      = transfer && (ones != 1);
         stalled  = (errLeft == 0) && mAct && (idx >= 0) && !rdyVec[idx];
         expire   = stalled && (stallCnt + 1 == TMO);
         if (errLeft == 2)        errLeft = 1;
         else if (bad || expire)  errLeft = 2;
         else                     errLeft = 0;
         stallCnt = stalled ? stallCnt + 1 : 0;
         if (expire)   mTmo = 1'b1;
         else if (clr) mTmo = 1'b0;
         if (transfer && ones > 1) mSelErr = 1'b1;
         if (expReady) begin
            mSel = sel;
            mAct = trans[1];
         end
      end
   endtask

   // One bus cycle: drive on the falling edge, compare shortly after, then advance the model.
   task automatic applyStimulus(input logic r, input logic [NS-1:0] s, input logic [1:0] t,
                                input logic [NS-1:0] rdy, input logic [NS-1:0] rsp,
                                input logic c, input int dPort = -1,
                                input logic [DW-1:0] dVal = '0);
      @(negedge clock);
      reset   = r;
      sel     = s;
      trans   = t;
      rdyVec  = rdy;
      respVec = rsp;
      clr     = c;
      for (int i = 0; i < NS; i++) dataVec[i*DW +: DW] = $urandom;
      if (dPort >= 0) dataVec[dPort*DW +: DW] = dVal;
      #1;
      modelOutputs();
      checkOutput("hreadyout", 32'(hreadyOut), 32'(expReady));
      checkOutput("hresp", 32'(hresp), 32'(expResp));
      checkOutput("hrdata", 32'(hrdata), 32'(expData));
      checkOutput("timeout_flag", 32'(tmoFlag), 32'(mTmo));
      checkOutput("sel_err_flag", 32'(selErrFlag), 32'(mSelErr));
      modelStep();
   endtask

   initial begin
      logic [NS-1:0] slow2;
      int            r;
      slow2   = ALL & ~oneHot(2);
      reset   = 1'b1;
      sel     = '0;
      trans   = IDLE;
      rdyVec  = ALL;
      respVec = '0;
      dataVec = '0;
      clr     = 1'b0;
      @(posedge clock);

      applyStimulus(1'b1, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("rst_ready", 32'(hreadyOut), 32'd1);
      checkOutput("rst_resp", 32'(hresp), 32'd0);
      checkOutput("rst_data", 32'(hrdata), 32'd0);

      // NONSEQ to port 5 with a ready slave.
      applyStimulus(1'b0, oneHot(5), NONSEQ, ALL, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0, 5, 32'hCAFE0005);
      checkOutput("t1_data", 32'(hrdata), 32'hCAFE0005);
      checkOutput("t1_ready", 32'(hreadyOut), 32'd1);

      // Port 12 inserts three wait states.
      applyStimulus(1'b0, oneHot(12), NONSEQ, ALL, '0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, '0, IDLE, ALL & ~oneHot(12), '0, 1'b0);
         checkOutput("t2_wait", 32'(hreadyOut), 32'd0);
      end
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t2_done", 32'(hreadyOut), 32'd1);
      checkOutput("t2_noflag", 32'({tmoFlag, selErrFlag}), 32'd0);

      // Unmapped selects, back-to-back.
      applyStimulus(1'b0, '0, NONSEQ, ALL, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t3_err1", 32'({hreadyOut, hresp}), 32'b01);
      applyStimulus(1'b0, '0, NONSEQ, ALL, '0, 1'b0);
      checkOutput("t3_err2", 32'({hreadyOut, hresp}), 32'b11);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t3_err1b", 32'({hreadyOut, hresp}), 32'b01);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t3_err2b", 32'({hreadyOut, hresp}), 32'b11);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t3_okay", 32'({hreadyOut, hresp}), 32'b10);

      // Multi-hot select.
      applyStimulus(1'b0, NS'(3), NONSEQ, ALL, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t4_err1", 32'({hreadyOut, hresp}), 32'b01);
      checkOutput("t4_flag", 32'(selErrFlag), 32'd1);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t4_err2", 32'({hreadyOut, hresp}), 32'b11);

      // Port 2 never ready: watchdog abort after exactly TMO stalled cycles.
      applyStimulus(1'b0, oneHot(2), NONSEQ, ALL, '0, 1'b0);
      for (int k = 0; k < TMO; k++) begin
         applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
         checkOutput("t5_stall", 32'({hreadyOut, hresp}), 32'b00);
      end
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
      checkOutput("t5_err1", 32'({hreadyOut, hresp}), 32'b01);
      checkOutput("t5_flag", 32'(tmoFlag), 32'd1);
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
      checkOutput("t5_err2", 32'({hreadyOut, hresp}), 32'b11);
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b1);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t5_cleared", 32'(tmoFlag), 32'd0);
      checkOutput("t4_sticky", 32'(selErrFlag), 32'd1);

      // Reset during ERR1, then reset mid-stall.
      applyStimulus(1'b0, '0, NONSEQ, ALL, '0, 1'b0);
      applyStimulus(1'b1, '0, IDLE, ALL, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, ALL, '0, 1'b0);
      checkOutput("t6_after_err", 32'({hreadyOut, hresp, selErrFlag}), 32'b100);
      checkOutput("t6_data", 32'(hrdata), 32'd0);
      applyStimulus(1'b0, oneHot(2), NONSEQ, ALL, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
      applyStimulus(1'b1, '0, IDLE, slow2, '0, 1'b0);
      applyStimulus(1'b0, oneHot(2), NONSEQ, slow2, '0, 1'b0);
      checkOutput("t6_after_stall", 32'({hreadyOut, hresp}), 32'b10);
      for (int k = 0; k < TMO; k++) begin
         applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
         checkOutput("t6_full_stall", 32'(hreadyOut), 32'd0);
      end
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);
      checkOutput("t6_abort", 32'({hreadyOut, hresp}), 32'b01);
      applyStimulus(1'b0, '0, IDLE, slow2, '0, 1'b0);

      // Random traffic with occasional resets and flag clears.
      for (int n = 0; n < 3000; n++) begin
         logic [NS-1:0] s;
         r = $urandom_range(0, 9);
         if (r < 7)       s = oneHot($urandom_range(0, NS - 1));
         else if (r == 7) s = '0;
         else             s = NS'($urandom);
         applyStimulus(($urandom_range(0, 299) == 0), s, 2'($urandom), NS'($urandom),
                       NS'($urandom & $urandom & $urandom), ($urandom_range(0, 15) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
